// File: rtl/ebus_arb_pkg.sv
// Shared types for the EBUS arbiter: FSM states, fixed slot numbers, one-hot encode helper.
package ebus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        OWNED,
        TURN
    } state_t;

    localparam int PI_SLOT      = 0;
    localparam int EBOX_SLOT    = 1;
    localparam int CONSOLE_SLOT = 2;

    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ebus_arb_if.sv
// EBUS request/grant bundle: requesters sit on the master side, the arbiter on the slave side.
interface ebus_arb_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] rel;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] drive_en;
    logic            busy;
    logic [2:0]      owner;

    modport master (
        output req, rel,
        input  grant, drive_en, busy, owner
    );

    modport slave (
        input  req, rel,
        output grant, drive_en, busy, owner
    );
endinterface

// File: rtl/ebus_arb_pick.sv
// Winner select: slot 0 absolute priority, then fixed lowest-index or round-robin (EBUS_ARB_RR_EN).
// Latency: combinational.
// Backpressure: none; caller decides when the one-hot result is taken.
module ebus_arb_pick
    import ebus_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      pointer,
    output logic [NREQ-1:0] winner
);

`ifdef EBUS_ARB_RR_EN
    logic [NREQ-1:0] spare;
    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] hi;

    // Search spare slots from the pointer upward; if none there, wrap to the lowest spare slot.
    always_comb begin
        winner = '0;
        spare  = req;
        spare[PI_SLOT] = 1'b0;
        mask   = '0;
        for (int j = 1; j < NREQ; j++) begin
            mask[j] = (3'(j) >= pointer);
        end
        hi = spare & mask;
        if (req[PI_SLOT]) begin
            winner[PI_SLOT] = 1'b1;
        end else if (|hi) begin
            winner = hi & (~hi + NREQ'(1));
        end else begin
            winner = spare & (~spare + NREQ'(1));
        end
    end
`else
    logic unused_pointer;
    assign unused_pointer = ^pointer;

    // Lowest set bit wins, which also gives slot 0 absolute priority.
    assign winner = req & (~req + NREQ'(1));
`endif

endmodule

// File: rtl/ebus_arb.sv
// EBUS arbiter: grant -> settle -> owned -> turnaround tenure with hung-owner watchdog; EBUS_ARB_RR_EN selects round-robin.
// Latency: grant 1 cycle after req in IDLE, drive_en 1 cycle after grant, release drops grant/drive_en next edge.
// Backpressure: none; requesters hold req until granted, the watchdog reclaims a bus held too long.
module ebus_arb
    import ebus_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64,
    parameter int CNTW    = 7
) (
    input  logic        clk,
    input  logic        RESET,
    ebus_arb_if.slave   bus,
    input  logic        clr_timeout,
    output logic        timeout,
    output logic [2:0]  timeout_who
);

    state_t          state;
    logic [CNTW-1:0] count;
    logic [NREQ-1:0] win;
    logic [2:0]      ptr;
    logic            own_req;
    logic            own_rel;
    logic            wd_hit;
    logic            wd_fire;

`ifdef EBUS_ARB_RR_EN
    logic [2:0] win_idx;
    assign win_idx = onehot_to_idx(8'(win));

    // Slot 0 grants leave the rotation where it was.
    always_ff @(posedge clk) begin
        if (RESET) begin
            ptr <= 3'(EBOX_SLOT);
        end else if (state == IDLE && |bus.req && !win[PI_SLOT]) begin
            ptr <= (win_idx == 3'(NREQ - 1)) ? 3'(EBOX_SLOT) : win_idx + 3'd1;
        end
    end
`else
    assign ptr = 3'(EBOX_SLOT);
`endif

    ebus_arb_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req     (bus.req),
        .pointer (ptr),
        .winner  (win)
    );

    // grant is one-hot on the owner while SETTLE/OWNED, so it doubles as the owner mask.
    assign own_req = |(bus.req & bus.grant);
    assign own_rel = |(bus.rel & bus.grant);
    assign wd_hit  = (count == CNTW'(TIMEOUT - 1));
    assign wd_fire = (state == OWNED) && wd_hit && own_req && !own_rel;

    always_ff @(posedge clk) begin
        if (RESET) begin
            state        <= IDLE;
            bus.grant    <= '0;
            bus.drive_en <= '0;
            bus.busy     <= 1'b0;
            bus.owner    <= 3'd0;
            timeout      <= 1'b0;
            timeout_who  <= 3'd0;
            count        <= '0;
        end else begin
            if (wd_fire) begin
                timeout     <= 1'b1;
                timeout_who <= bus.owner;
            end else if (clr_timeout) begin
                timeout <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        bus.grant <= win;
                        bus.owner <= onehot_to_idx(8'(win));
                        bus.busy  <= 1'b1;
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (!own_req) begin
                        bus.grant <= '0;
                        state     <= TURN;
                    end else begin
                        bus.drive_en <= bus.grant;
                        count        <= '0;
                        state        <= OWNED;
                    end
                end
                OWNED: begin
                    count <= count + CNTW'(1);
                    if (own_rel || !own_req || wd_hit) begin
                        bus.grant    <= '0;
                        bus.drive_en <= '0;
                        state        <= TURN;
                    end
                end
                TURN: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ebus_arb.sv
// Bench for ebus_arb: vector table plus watchdog and rotation sequences, checked through an expected-result queue.
module tb_ebus_arb;
    import ebus_arb_pkg::*;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 8;
    localparam int CNTW    = 4;
`ifdef EBUS_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] rel;
        logic       clr;
        logic [3:0] eg;
        logic [3:0] ed;
        logic       eb;
        logic [2:0] eo;
        logic       et;
        logic [2:0] ew;
    } vec_t;

    logic       clk = 1'b0;
    logic       RESET = 1'b1;
    logic       clr_timeout = 1'b0;
    logic       timeout;
    logic [2:0] timeout_who;

    ebus_arb_if #(.NREQ(NREQ)) bus ();

    ebus_arb #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT),
        .CNTW    (CNTW)
    ) dut (
        .clk         (clk),
        .RESET       (RESET),
        .bus         (bus),
        .clr_timeout (clr_timeout),
        .timeout     (timeout),
        .timeout_who (timeout_who)
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   viol   = 0;
    int   step   = 0;
    logic       cur_to  = 1'b0;
    logic [2:0] cur_who = 3'd0;
    vec_t tbl[$];
    vec_t sbq[$];

    function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic [3:0] rel,
                                input logic clr, input logic [3:0] eg, input logic [3:0] ed,
                                input logic eb, input logic [2:0] eo, input logic et,
                                input logic [2:0] ew);
        vec_t v;
        v.rst = rst; v.req = req; v.rel = rel; v.clr = clr;
        v.eg = eg; v.ed = ed; v.eb = eb; v.eo = eo; v.et = et; v.ew = ew;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
        else
            n_pass++;
    endtask

    task automatic cyc(input vec_t v);
        vec_t e;
        @(negedge clk);
        RESET       = v.rst;
        bus.req     = v.req;
        bus.rel     = v.rel;
        clr_timeout = v.clr;
        sbq.push_back(v);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("grant",       32'(bus.grant),    32'(e.eg));
        chk("drive_en",    32'(bus.drive_en), 32'(e.ed));
        chk("busy",        32'(bus.busy),     32'(e.eb));
        chk("owner",       32'(bus.owner),    32'(e.eo));
        chk("timeout",     32'(timeout),      32'(e.et));
        chk("timeout_who", 32'(timeout_who),  32'(e.ew));
        step++;
    endtask

    // Holds one slot with no release; the watchdog must reclaim it 8 edges after OWNED is entered.
    task automatic wd_run(input int slot, input logic rel_end, input logic clr_end,
                          input logic to_after, input logic [2:0] who_after);
        logic [3:0] oh;
        oh = 4'(1) << slot;
        cyc(mk(0, oh, 4'h0, 0, oh, 4'h0, 1, 3'(slot), cur_to, cur_who));
        cyc(mk(0, oh, 4'h0, 0, oh, oh, 1, 3'(slot), cur_to, cur_who));
        for (int i = 0; i < TIMEOUT - 1; i++)
            cyc(mk(0, oh, 4'h0, 0, oh, oh, 1, 3'(slot), cur_to, cur_who));
        cyc(mk(0, oh, rel_end ? oh : 4'h0, clr_end, 4'h0, 4'h0, 1, 3'(slot), to_after, who_after));
        cur_to  = to_after;
        cur_who = who_after;
        cyc(mk(0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 3'(slot), cur_to, cur_who));
    endtask

    always @(negedge clk) begin
        if (!$onehot0(bus.grant) || !$onehot0(bus.drive_en) ||
            (bus.drive_en & ~bus.grant) != 4'h0 ||
            (dut.state == TURN && bus.drive_en != 4'h0)) begin
            viol++;
            $display("FAIL invariant at %0t: grant=%b drive_en=%b", $time, bus.grant, bus.drive_en);
        end
    end

    initial begin
        #100000;
        $display("FAIL time_limit: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    initial begin
        logic [3:0] g2;
        logic [2:0] o2;
        logic [3:0] rr_oh;
        int         rr_s;
        g2 = RR ? 4'b0100 : 4'b0010;
        o2 = RR ? 3'd2 : 3'd1;
        bus.req = '0;
        bus.rel = '0;

        // rst req rel clr | grant drive_en busy owner timeout who
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 3'd0, 0, 3'd0));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 0, 4'b0010, 4'b0000, 1, 3'd1, 0, 3'd0));
        tbl.push_back(mk(0, 4'b0010, 4'b0010, 0, 4'b0010, 4'b0010, 1, 3'd1, 0, 3'd0));
        tbl.push_back(mk(0, 4'b0110, 4'b0000, 0, 4'b0010, 4'b0010, 1, 3'd1, 0, 3'd0));
        tbl.push_back(mk(0, 4'b0010, 4'b1000, 0, 4'b0010, 4'b0010, 1, 3'd1, 0, 3'd0));
        tbl.push_back(mk(0, 4'b0010, 4'b0010, 0, 4'b0000, 4'b0000, 1, 3'd1, 0, 3'd0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 3'd1, 0, 3'd0));
        tbl.push_back(mk(0, 4'b0000, 4'b1111, 1, 4'b0000, 4'b0000, 0, 3'd1, 0, 3'd0));
        tbl.push_back(mk(0, 4'b0111, 4'b0000, 0, 4'b0001, 4'b0000, 1, 3'd0, 0, 3'd0));
        tbl.push_back(mk(0, 4'b0111, 4'b0000, 0, 4'b0001, 4'b0001, 1, 3'd0, 0, 3'd0));
        tbl.push_back(mk(0, 4'b0111, 4'b0001, 0, 4'b0000, 4'b0000, 1, 3'd0, 0, 3'd0));
        tbl.push_back(mk(0, 4'b0110, 4'b0000, 0, 4'b0000, 4'b0000, 0, 3'd0, 0, 3'd0));
        tbl.push_back(mk(0, 4'b0110, 4'b0000, 0, g2,      4'b0000, 1, o2,   0, 3'd0));
        tbl.push_back(mk(0, 4'b0110, 4'b0000, 0, g2,      g2,      1, o2,   0, 3'd0));
        tbl.push_back(mk(0, 4'b0110, g2,      0, 4'b0000, 4'b0000, 1, o2,   0, 3'd0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, o2,   0, 3'd0));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 0, 4'b0010, 4'b0000, 1, 3'd1, 0, 3'd0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 1, 3'd1, 0, 3'd0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 3'd1, 0, 3'd0));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 0, 4'b0100, 4'b0000, 1, 3'd2, 0, 3'd0));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 0, 4'b0100, 4'b0100, 1, 3'd2, 0, 3'd0));
        tbl.push_back(mk(1, 4'b0100, 4'b0000, 0, 4'b0000, 4'b0000, 0, 3'd0, 0, 3'd0));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 0, 4'b0100, 4'b0000, 1, 3'd2, 0, 3'd0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 1, 3'd2, 0, 3'd0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 3'd2, 0, 3'd0));

        foreach (tbl[i]) cyc(tbl[i]);

        // Plain watchdog fire on the console slot, then clear.
        wd_run(CONSOLE_SLOT, 1'b0, 1'b0, 1'b1, 3'd2);
        cyc(mk(0, 4'h0, 4'h0, 1, 4'h0, 4'h0, 0, 3'd2, 0, 3'd2));
        cur_to = 1'b0;
        // Release coinciding with expiry is a normal release.
        wd_run(3, 1'b1, 1'b0, 1'b0, 3'd2);
        // Clear coinciding with a fire loses to the set.
        wd_run(3, 1'b0, 1'b1, 1'b1, 3'd3);
        cyc(mk(0, 4'h0, 4'h0, 1, 4'h0, 4'h0, 0, 3'd3, 0, 3'd3));

        // Three spare slots held; each owner releases after three owned cycles.
        cyc(mk(1, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 3'd0, 0, 3'd0));
        for (int t = 0; t < 4; t++) begin
            rr_s  = RR ? ((t % 3) + EBOX_SLOT) : EBOX_SLOT;
            rr_oh = 4'(1) << rr_s;
            cyc(mk(0, 4'b1110, 4'h0, 0, rr_oh, 4'h0, 1, 3'(rr_s), 0, 3'd0));
            for (int k = 0; k < 3; k++)
                cyc(mk(0, 4'b1110, 4'h0, 0, rr_oh, rr_oh, 1, 3'(rr_s), 0, 3'd0));
            cyc(mk(0, 4'b1110, rr_oh, 0, 4'h0, 4'h0, 1, 3'(rr_s), 0, 3'd0));
            cyc(mk(0, 4'b1110, 4'h0, 0, 4'h0, 4'h0, 0, 3'(rr_s), 0, 3'd0));
        end

        chk("invariants", 32'(viol), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
